pcap_frame_extractor: RTL and testbench
=======================================

Name: pcap_frame_extractor

Overview:
- Upstream neighbour of the UDP reader: consumes a raw PCAP byte stream (global header, then per-record headers and captured frames) from an 8-bit input FIFO.
- Writes captured frames to a 10-bit output FIFO with start-of-frame and end-of-frame flags; the UDP reader's input FIFO consumes that stream.
- Strips all PCAP headers, validates the magic number, and drops zero-length and oversize records.

Parameters:
- MAX_FRAME_LEN, 1518: largest incl_len forwarded; longer records are consumed and dropped.
- CNT_WIDTH, 16: width of the frame and drop counters.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- in_empty  in  1  input FIFO empty.
- in_dout  in  8  input FIFO data, first-word-fall-through: valid whenever in_empty=0.
- in_re  out  1  input FIFO pop.
- out_full  in  1  output FIFO full.
- out_we  out  1  output FIFO push.
- out_din  out  10  {sof, eof, byte[7:0]}.
- frame_count  out  CNT_WIDTH  frames forwarded (counted on eof write).
- drop_count  out  CNT_WIDTH  records dropped (zero-length or oversize).
- bad_magic  out  1  sticky: global header magic mismatch.

Behaviour:
- Reset (reset=0, async):
  - State=GLOBAL_HDR, byte counter=0.
  - in_re=0, out_we=0, out_din=0, counters=0, bad_magic=0.
- Pop rule: a byte is consumed only in a cycle with in_re=1 and in_empty=0. in_re is never asserted while in_empty=1.
- GLOBAL_HDR:
  - in_re = !in_empty. Consume 24 bytes.
  - Bytes 0..3 must equal D4 C3 B2 A1 (little-endian 0xA1B2C3D4).
  - After byte 23: go to ERROR on any mismatch, else go to REC_HDR.
- ERROR:
  - bad_magic=1, in_re=0 permanently.
  - Only reset exits this state.
- REC_HDR:
  - in_re = !in_empty. Consume 16 bytes.
  - Bytes 8..11 form incl_len, little-endian, 32 bits.
  - After byte 15:
    - incl_len==0: drop_count+1, stay in REC_HDR.
    - incl_len>MAX_FRAME_LEN: load remaining=incl_len, drop_count+1, go to DROP.
    - Otherwise: load remaining=incl_len, go to PAYLOAD.
- PAYLOAD:
  - in_re = out_we = !in_empty && !out_full. The input byte passes through combinationally to out_din in the same cycle (zero latency).
  - sof=1 on the first byte of the record. eof=1 when remaining==1. A 1-byte record gives sof=eof=1.
  - Each transfer decrements remaining.
  - On the eof transfer: frame_count+1, go to REC_HDR.
  - Stall: when out_full=1 or in_empty=1, nothing is popped or pushed and state holds.
- DROP:
  - in_re = !in_empty, out_we=0.
  - Decrement remaining per pop. On the last byte, go to REC_HDR.
- Counters wrap modulo 2^CNT_WIDTH.
- out_din=0 whenever out_we=0.
- Byte counter is 5 bits (max 23) and clears on every header-state entry.
- Mid-operation reset: the partial frame is abandoned with no eof emitted. The downstream reader resyncs on the next sof.

Decomposition:
- Package pcap_pkg:
  - state enum {GLOBAL_HDR, REC_HDR, PAYLOAD, DROP, ERROR}.
  - Constants: PCAP_GLOBAL_HDR_LEN=24, PCAP_REC_HDR_LEN=16, PCAP_MAGIC=32'hA1B2C3D4, INCL_LEN_OFFSET=8.
  - Bit-position constants SOF_BIT=9, EOF_BIT=8, shared with the UDP reader.
- Single module; no sub-module is needed.
- The top-level wrapper instantiates this block with an input fifo (width 8) and shares its output fifo with the UDP reader's input.

Test Plan:
- Valid global header, then one record with incl_len=4 and payload 11 22 33 44, output never full -> out_din = 0x211, 0x022, 0x033, 0x144 on 4 consecutive cycles; frame_count=1.
- Magic bytes A1 B2 C3 D4 (wrong order) -> after 24 pops, bad_magic=1 and in_re stays 0 with further bytes queued; reset clears bad_magic.
- Records of incl_len=0, then 1 (byte 0x5A), then 2000 with MAX_FRAME_LEN=1518 -> single output 0x35A; drop_count=2; all 2000 dropped bytes popped with out_we=0.
- incl_len=3 payload AA BB CC with out_full held high for 5 cycles after the first byte -> no pops during the stall; output order 0x2AA, 0x0BB, 0x1CC; nothing lost or duplicated.
- in_empty toggling every other cycle through headers and payload -> identical output stream to the no-gap case.
- Assert reset after 2 of 4 payload bytes -> outputs go to zero immediately, no eof; next stream is parsed from GLOBAL_HDR correctly.

Source files
------------

// File: rtl/pcap_pkg.sv
// Shared PCAP parsing types and constants for the frame extractor and the UDP reader.
// Holds the FSM state encoding, header geometry and the output-word flag positions.
package pcap_pkg;

  typedef enum logic [2:0] {
    GLOBAL_HDR,
    REC_HDR,
    PAYLOAD,
    DROP,
    ERROR
  } state_t;

  localparam int          PCAP_GLOBAL_HDR_LEN = 24;
  localparam int          PCAP_REC_HDR_LEN    = 16;
  localparam logic [31:0] PCAP_MAGIC          = 32'hA1B2C3D4;
  localparam int          INCL_LEN_OFFSET     = 8;

  localparam int SOF_BIT = 9;
  localparam int EOF_BIT = 8;

  // Magic arrives little-endian, so byte idx of the stream is bits [8*idx +: 8].
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return 8'(PCAP_MAGIC >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/pcap_frame_extractor.sv
// Strips PCAP global/record headers and forwards captured frames as {sof, eof, byte}.
// Payload bytes pass through with zero latency; payload stalls on out_full or in_empty.
module pcap_frame_extractor
  import pcap_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_empty,
  input  logic [7:0]           in_dout,
  output logic                 in_re,
  input  logic                 out_full,
  output logic                 out_we,
  output logic [9:0]           out_din,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 bad_magic
);

  state_t      state, state_nxt;
  logic [4:0]  byte_cnt;
  logic [31:0] incl_len;
  logic [31:0] remaining;
  logic        sof_pend;
  logic        magic_err;
  logic        glob_last;
  logic        rec_last;

  assign glob_last = (byte_cnt == 5'(PCAP_GLOBAL_HDR_LEN - 1));
  assign rec_last  = (byte_cnt == 5'(PCAP_REC_HDR_LEN - 1));
  assign bad_magic = (state == ERROR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= GLOBAL_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_re     = 1'b0;
    out_we    = 1'b0;
    out_din   = '0;
    case (state)
      GLOBAL_HDR: begin
        in_re = !in_empty;
        if (in_re && glob_last) state_nxt = magic_err ? ERROR : REC_HDR;
      end
      REC_HDR: begin
        in_re = !in_empty;
        if (in_re && rec_last) begin
          if (incl_len == 32'd0)                    state_nxt = REC_HDR;
          else if (incl_len > 32'(MAX_FRAME_LEN))   state_nxt = DROP;
          else                                      state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        in_re  = !in_empty && !out_full;
        out_we = in_re;
        if (out_we) begin
          out_din[SOF_BIT] = sof_pend;
          out_din[EOF_BIT] = (remaining == 32'd1);
          out_din[7:0]     = in_dout;
          if (remaining == 32'd1) state_nxt = REC_HDR;
        end
      end
      DROP: begin
        in_re = !in_empty;
        if (in_re && remaining == 32'd1) state_nxt = REC_HDR;
      end
      default: ;
    endcase
    // Outputs are forced quiet while reset is held, whatever state is decoded.
    if (!reset) begin
      in_re   = 1'b0;
      out_we  = 1'b0;
      out_din = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt    <= '0;
      incl_len    <= '0;
      remaining   <= '0;
      sof_pend    <= 1'b0;
      magic_err   <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else if (in_re) begin
      case (state)
        GLOBAL_HDR: begin
          byte_cnt <= glob_last ? 5'd0 : byte_cnt + 5'd1;
          if (byte_cnt < 5'd4 && in_dout != magic_byte(byte_cnt[1:0])) magic_err <= 1'b1;
        end
        REC_HDR: begin
          byte_cnt <= rec_last ? 5'd0 : byte_cnt + 5'd1;
          if (byte_cnt >= 5'(INCL_LEN_OFFSET) && byte_cnt < 5'(INCL_LEN_OFFSET + 4))
            incl_len <= {in_dout, incl_len[31:8]};
          if (rec_last) begin
            if (incl_len == 32'd0) begin
              drop_count <= drop_count + CNT_WIDTH'(1);
            end else begin
              remaining <= incl_len;
              sof_pend  <= 1'b1;
              if (incl_len > 32'(MAX_FRAME_LEN)) drop_count <= drop_count + CNT_WIDTH'(1);
            end
          end
        end
        PAYLOAD: begin
          remaining <= remaining - 32'd1;
          sof_pend  <= 1'b0;
          if (remaining == 32'd1) frame_count <= frame_count + CNT_WIDTH'(1);
        end
        DROP: remaining <= remaining - 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcap_frame_extractor.sv
// Directed bench: FWFT input FIFO model feeding the extractor, scoreboard of expected output words.
module tb_pcap_frame_extractor;

  logic        clock;
  logic        reset;
  logic        in_empty;
  logic [7:0]  in_dout;
  logic        in_re;
  logic        out_full;
  logic        out_we;
  logic [9:0]  out_din;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic        bad_magic;

  pcap_frame_extractor #(.MAX_FRAME_LEN(1518), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout), .in_re(in_re),
    .out_full(out_full), .out_we(out_we), .out_din(out_din),
    .frame_count(frame_count), .drop_count(drop_count), .bad_magic(bad_magic)
  );

  logic [7:0] bq[$];
  logic [9:0] exp_q[$];
  int         out_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         stall_cnt = 0;
  int         full_cycles = 0;
  logic       stall_arm = 1'b0;
  logic       gap_mode = 1'b0;
  logic       gap = 1'b0;
  logic       pop_pend;
  logic [9:0] e;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_global(input logic [31:0] magic);
    for (int i = 0; i < 4; i++) bq.push_back(magic[8*i +: 8]);
    for (int i = 4; i < 24; i++) bq.push_back(8'(i));
  endtask

  task automatic push_rec(input logic [31:0] len);
    for (int i = 0; i < 8; i++) bq.push_back(8'hEE);
    for (int i = 0; i < 4; i++) bq.push_back(len[8*i +: 8]);
    for (int i = 0; i < 4; i++) bq.push_back(len[8*i +: 8]);
  endtask

  task automatic pay(input logic [7:0] b, input logic [9:0] w);
    bq.push_back(b);
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((bq.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < budget), 32'd1);
    repeat (3) @(posedge clock);
    #2;
  endtask

  // Input FIFO model and output monitor: sample mid-cycle, apply pops just after the edge.
  initial begin
    in_empty = 1'b1;
    in_dout  = 8'h00;
    out_full = 1'b0;
    forever begin
      @(negedge clock);
      pop_pend = in_re && !in_empty;
      chk("pop_while_empty", 32'(in_re && in_empty), 32'd0);
      if (out_we) begin
        out_cyc.push_back(cyc);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out observed=%03h expected=none", out_din);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_din", 32'(out_din), 32'(e));
        end
        if (stall_arm && out_din == 10'h2AA) begin
          stall_cnt = 5;
          stall_arm = 1'b0;
        end
      end else begin
        chk("out_din_idle", 32'(out_din), 32'd0);
      end
      if (out_full) begin
        full_cycles++;
        chk("stall_no_pop", 32'({in_re, out_we}), 32'd0);
      end
      @(posedge clock);
      cyc++;
      #1;
      if (pop_pend && bq.size() > 0) bq.delete(0);
      gap      = gap_mode ? !gap : 1'b0;
      out_full = (stall_cnt > 0);
      if (stall_cnt > 0) stall_cnt--;
      in_empty = gap || (bq.size() == 0);
      in_dout  = (bq.size() != 0) ? bq[0] : 8'h00;
    end
  end

  initial begin
    reset = 1'b0;
    push_global(32'hA1B2C3D4);
    repeat (3) @(posedge clock);
    #2;
    chk("rst_in_re", 32'(in_re), 0);
    chk("rst_out_we", 32'(out_we), 0);
    chk("rst_out_din", 32'(out_din), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk("rst_bad_magic", 32'(bad_magic), 0);
    reset = 1'b1;

    // One 4-byte record, output never full.
    out_cyc.delete();
    push_rec(4);
    pay(8'h11, 10'h211); pay(8'h22, 10'h022); pay(8'h33, 10'h033); pay(8'h44, 10'h144);
    drain("rec4", 200);
    chk("rec4_nout", 32'(out_cyc.size()), 4);
    if (out_cyc.size() == 4) chk("rec4_consecutive", 32'(out_cyc[3] - out_cyc[0]), 3);
    chk("rec4_frame_count", 32'(frame_count), 1);
    chk("rec4_bad_magic", 32'(bad_magic), 0);

    // Zero-length, one-byte and oversize records.
    push_rec(0);
    push_rec(1);
    pay(8'h5A, 10'h35A);
    push_rec(2000);
    for (int i = 0; i < 2000; i++) bq.push_back(8'(i));
    drain("drop", 3000);
    chk("drop_all_popped", 32'(bq.size()), 0);
    chk("drop_count", 32'(drop_count), 2);
    chk("drop_frame_count", 32'(frame_count), 2);

    // Output stalls for 5 cycles after the first payload byte.
    full_cycles = 0;
    stall_arm   = 1'b1;
    push_rec(3);
    pay(8'hAA, 10'h2AA); pay(8'hBB, 10'h0BB); pay(8'hCC, 10'h1CC);
    drain("stall", 200);
    chk("stall_cycles", 32'(full_cycles), 5);
    chk("stall_frame_count", 32'(frame_count), 3);

    // Input empty every other cycle through header and payload.
    gap_mode = 1'b1;
    push_rec(4);
    pay(8'h11, 10'h211); pay(8'h22, 10'h022); pay(8'h33, 10'h033); pay(8'h44, 10'h144);
    drain("gap", 400);
    gap_mode = 1'b0;
    chk("gap_frame_count", 32'(frame_count), 4);
    chk("gap_drop_count", 32'(drop_count), 2);

    // Byte-swapped magic locks the block in its error state.
    reset = 1'b0;
    bq.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    push_global(32'hD4C3B2A1);
    for (int i = 0; i < 5; i++) bq.push_back(8'hF0 + 8'(i));
    repeat (60) @(posedge clock);
    #2;
    chk("magic_bad_magic", 32'(bad_magic), 1);
    chk("magic_in_re", 32'(in_re), 0);
    chk("magic_left_queued", 32'(bq.size()), 5);
    reset = 1'b0;
    #1;
    chk("magic_reset_clears", 32'(bad_magic), 0);
    bq.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;

    // Reset after two of four payload bytes; no eof may follow.
    push_global(32'hA1B2C3D4);
    push_rec(4);
    pay(8'h11, 10'h211); pay(8'h22, 10'h022);
    drain("partial", 200);
    @(posedge clock);
    #2;
    bq.push_back(8'h33);
    bq.push_back(8'h44);
    @(posedge clock);
    #2;
    chk("partial_we_before", 32'(out_we), 1);
    chk("partial_din_before", 32'(out_din), 32'h033);
    reset = 1'b0;
    #1;
    chk("partial_we_reset", 32'(out_we), 0);
    chk("partial_din_reset", 32'(out_din), 0);
    chk("partial_frame_count", 32'(frame_count), 0);
    bq.delete();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    push_global(32'hA1B2C3D4);
    push_rec(2);
    pay(8'h77, 10'h277); pay(8'h88, 10'h188);
    drain("resync", 200);
    chk("resync_frame_count", 32'(frame_count), 1);
    chk("resync_bad_magic", 32'(bad_magic), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
